chunked_adder: RTL and testbench

Parametrised, multi-cycle add/subtract unit: the successor to our 2-bit ripple full adder. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, rippling the carry between chunks through a registered carry. It supports add-with-carry-in and two's-complement subtract. It reports carry-out and signed overflow, and it talks to its controller with a start/busy/done handshake. It sits between the lab datapath registers and the result display/ALU mux.

---
 rtl/chunked_adder_if.sv | 30 +++
 rtl/chunked_adder.sv | 156 +++++++++++++++
 tb/tb_chunked_adder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/chunked_adder_if.sv
// rtl/chunked_adder_if.sv - start/busy/done handshake and operand/result bus for chunked_adder
//
// Purpose: groups the controller-facing signals of the chunked adder.
// Ports (per modport view):
//   master (controller): drives start, sub, a, b, cin; observes busy, done, sum, cout, overflow
//   slave  (adder):      observes start, sub, a, b, cin; drives busy, done, sum, cout, overflow
interface chunked_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle add/subtract processing CHUNK bits per clock
//
// Purpose: adds or subtracts two WIDTH-bit operands over K = WIDTH/CHUNK clocks,
// LSB chunk first, with the inter-chunk carry held in a register. Reports carry-out
// and signed overflow of the last completed operation.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - chunked_adder_if slave: start/sub/a/b/cin in; busy/done/sum/cout/overflow out
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic           clk,
    input  logic           reset,
    chunked_adder_if.slave bus
);
    localparam int K     = WIDTH / CHUNK;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             overflow_q;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             ripple_c;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic             last_chunk;
    logic             busy_c;
    logic             done_c;

    assign last_chunk = (idx == IDX_W'(K - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status decode; busy/done depend on state only, so no
    // input reaches an output combinationally.
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One chunk of 1-bit full adders. chunk_cmsb is the carry entering the top
    // bit of the chunk; on the last chunk that is the carry into the result MSB.
    always_comb begin
        chunk_a    = op_a[int'(idx) * CHUNK +: CHUNK];
        chunk_b    = op_b[int'(idx) * CHUNK +: CHUNK];
        chunk_sum  = '0;
        chunk_cmsb = 1'b0;
        ripple_c   = carry;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                chunk_cmsb = ripple_c;
            end
            chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ ripple_c;
            ripple_c     = (chunk_a[i] & chunk_b[i]) | (ripple_c & (chunk_a[i] ^ chunk_b[i]));
        end
        chunk_cout = ripple_c;

        work_next = work;
        work_next[int'(idx) * CHUNK +: CHUNK] = chunk_sum;
    end

    // Operand latch, chunk iteration and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a       <= '0;
            op_b       <= '0;
            work       <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract as A + ~B + 1: the inverted operand plus a forced carry-in.
                        op_a  <= bus.a;
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? 1'b1 : bus.cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= chunk_cout;
                    if (last_chunk) begin
                        idx        <= '0;
                        sum_q      <= work_next;
                        cout_q     <= chunk_cout;
                        overflow_q <= chunk_cmsb ^ chunk_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - directed self-checking bench for chunked_adder
module tb_chunked_adder;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   done_cnt0;
    int   done_cnt1;

    chunked_adder_if #(.WIDTH(8)) bus0 ();
    chunked_adder_if #(.WIDTH(8)) bus1 ();

    chunked_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        done_cnt0 <= done_cnt0 + ((bus0.done === 1'b1) ? 1 : 0);
        done_cnt1 <= done_cnt1 + ((bus1.done === 1'b1) ? 1 : 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic sb, input logic ci);
        if (which == 0) begin
            bus0.start = st; bus0.a = a; bus0.b = b; bus0.sub = sb; bus0.cin = ci;
        end else begin
            bus1.start = st; bus1.a = a; bus1.b = b; bus1.sub = sb; bus1.cin = ci;
        end
    endtask

    function automatic logic [11:0] outs(input int which);
        // {busy, done, cout, overflow, sum}
        if (which == 0) return {bus0.busy, bus0.done, bus0.cout, bus0.overflow, bus0.sum};
        return {bus1.busy, bus1.done, bus1.cout, bus1.overflow, bus1.sum};
    endfunction

    // Runs one operation and checks the busy/done timeline and the result.
    task automatic run_op(input string tag, input int which, input logic [7:0] a,
                          input logic [7:0] b, input logic sb, input logic ci,
                          input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int k;
        int d0;
        logic [11:0] o;
        k  = (which == 0) ? 4 : 1;
        d0 = (which == 0) ? done_cnt0 : done_cnt1;
        @(negedge clk);
        drive(which, 1'b1, a, b, sb, ci);
        @(negedge clk);
        drive(which, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        o = outs(which);
        check({tag, ".busy_e0"}, {31'd0, o[11]}, 32'd1);
        check({tag, ".done_e0"}, {31'd0, o[10]}, 32'd0);
        for (int n = 1; n <= k + 1; n++) begin
            @(negedge clk);
            o = outs(which);
            check($sformatf("%s.busy_e%0d", tag, n), {31'd0, o[11]}, {31'd0, (n <= k)});
            check($sformatf("%s.done_e%0d", tag, n), {31'd0, o[10]}, {31'd0, (n == k)});
            if (n == k) begin
                check({tag, ".sum"},      {24'd0, o[7:0]}, {24'd0, exp_sum});
                check({tag, ".cout"},     {31'd0, o[9]},   {31'd0, exp_cout});
                check({tag, ".overflow"}, {31'd0, o[8]},   {31'd0, exp_ovf});
            end
        end
        check({tag, ".done_count"}, ((which == 0) ? done_cnt0 : done_cnt1) - d0, 32'd1);
    endtask

    initial begin
        int d0;
        checks    = 0;
        errors    = 0;
        done_cnt0 = 0;
        done_cnt1 = 0;
        reset     = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset.outs0", {20'd0, outs(0)}, 32'd0);
        check("reset.outs1", {20'd0, outs(1)}, 32'd0);
        reset = 1'b0;

        run_op("add_ovf",  0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_cin",  0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("sub",      0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_ovf",  0, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Start pulses and operand changes during RUN must be ignored.
        d0 = done_cnt0;
        @(negedge clk);
        drive(0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("hs.done_e4", {31'd0, bus0.done}, 32'd1);
        check("hs.sum",     {24'd0, bus0.sum},  32'h46);
        check("hs.cout",    {31'd0, bus0.cout}, 32'd0);
        @(negedge clk);
        check("hs.busy_e5", {31'd0, bus0.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("hs.busy_idle",  {31'd0, bus0.busy}, 32'd0);
        check("hs.done_count", done_cnt0 - d0,     32'd1);
        check("hs.sum_hold",   {24'd0, bus0.sum},  32'h46);

        // Reset in the middle of RUN aborts without a done pulse.
        d0 = done_cnt0;
        @(negedge clk);
        drive(0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort.busy", {31'd0, bus0.busy},     32'd0);
        check("abort.done", {31'd0, bus0.done},     32'd0);
        check("abort.sum",  {24'd0, bus0.sum},      32'd0);
        check("abort.cout", {31'd0, bus0.cout},     32'd0);
        check("abort.ovf",  {31'd0, bus0.overflow}, 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort.done_count", done_cnt0 - d0,   32'd0);
        check("abort.busy_idle",  {31'd0, bus0.busy}, 32'd0);
        run_op("after_abort", 0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

        // Degenerate K=1 instance
        run_op("k1", 1, 8'hAA, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("k1_sub", 1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
